// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture/scaler slice.
// - OUT_FMT encodings for the pixel converter
// - capture FSM state encoding
// - fmt_dw(): output pixel width for a given OUT_FMT
package cam_pkg;

  localparam int FMT_RGB332 = 0;
  localparam int FMT_RGB444 = 1;
  localparam int FMT_RGB565 = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_WAIT_ROW,
    ST_ROW_CAPTURE,
    ST_ROW_SKIP,
    ST_DONE
  } cap_state_e;

  function automatic int fmt_dw(input int fmt);
    return (fmt == FMT_RGB565) ? 16 : (fmt == FMT_RGB444) ? 12 : 8;
  endfunction

endpackage

// File: rtl/pix_fmt_conv.sv
// Combinational RGB565 -> OUT_FMT converter (truncates low colour bits).
// Ports:
//   rgb565  in  16  source pixel {R[4:0],G[5:0],B[4:0]}
//   pix     out DW  converted pixel, DW = fmt_dw(OUT_FMT)
module pix_fmt_conv
  import cam_pkg::*;
#(
  parameter  int OUT_FMT = FMT_RGB332,
  localparam int DW      = fmt_dw(OUT_FMT)
) (
  input  logic [15:0]   rgb565,
  output logic [DW-1:0] pix
);

  generate
    if (OUT_FMT == FMT_RGB565) begin : g_565
      assign pix = rgb565;
    end else if (OUT_FMT == FMT_RGB444) begin : g_444
      assign pix = {rgb565[15:12], rgb565[10:7], rgb565[4:1]};
      // dropped LSBs of each channel
      logic unused_bits;
      assign unused_bits = ^{rgb565[11], rgb565[6:5], rgb565[0]};
    end else begin : g_332
      assign pix = {rgb565[15:13], rgb565[10:8], rgb565[4:3]};
      logic unused_bits;
      assign unused_bits = ^{rgb565[12:11], rgb565[7:5], rgb565[2:0]};
    end
  endgenerate

endmodule

// File: rtl/cam_capture_scaler.sv
// Camera capture with integer decimation and format conversion into a
// dual-port RAM. One frame is captured per arm (capture_en), starting at
// the first vsync falling edge seen after arming.
// Ports:
//   pclk, rst_n      pixel clock, async active-low reset
//   data/href/vsync  camera byte bus (two bytes per RGB565 pixel, MSB first)
//   capture_en       arm capture of the next frame
//   DP_RAM_*         registered write port (addr/data/strobe)
//   frame_done       one-cycle pulse after a captured frame ends
//   frame_short      sticky: last frame ended before all rows were written
module cam_capture_scaler
  import cam_pkg::*;
#(
  parameter  int IMG_W   = 160,
  parameter  int IMG_H   = 120,
  parameter  int DEC_X   = 4,
  parameter  int DEC_Y   = 4,
  parameter  int OUT_FMT = FMT_RGB332,
  parameter  int AW      = 15,
  localparam int DW      = fmt_dw(OUT_FMT)
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic [7:0]    data,
  input  logic          href,
  input  logic          vsync,
  input  logic          capture_en,
  output logic [AW-1:0] DP_RAM_addr_out,
  output logic [DW-1:0] DP_RAM_data_out,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic          frame_short
);

  localparam logic [2:0]    DX_MAX = 3'(DEC_X - 1);
  localparam logic [2:0]    DY_MAX = 3'(DEC_Y - 1);
  localparam logic [AW-1:0] W_L    = AW'(IMG_W);
  localparam logic [AW-1:0] H_L    = AW'(IMG_H);
  localparam logic [AW-1:0] W_LAST = AW'(IMG_W - 1);
  localparam logic [AW-1:0] H_LAST = AW'(IMG_H - 1);

  cap_state_e    state, state_nxt;
  logic          vsync_q, href_q, phase;
  logic [7:0]    hi_byte;
  logic [2:0]    src_col_m, src_row_m;   // source col/row modulo DEC_X/DEC_Y
  logic [AW-1:0] out_col, out_row, row_base;
  logic [DW-1:0] pix_conv;

  logic vs_fall, vs_rise, hr_rise, hr_fall;
  logic in_frame, abort, row_keep, col_keep;
  logic cap_byte, pix_done, wr_en, last_px, row_end;

  assign vs_fall = vsync_q & ~vsync;
  assign vs_rise = ~vsync_q & vsync;
  assign hr_rise = href & ~href_q;
  assign hr_fall = ~href & href_q;

  pix_fmt_conv #(.OUT_FMT(OUT_FMT)) u_conv (
    .rgb565 ({hi_byte, data}),
    .pix    (pix_conv)
  );

  // state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (capture_en) state_nxt = ST_WAIT_FRAME;
      ST_WAIT_FRAME:  if (vs_fall)    state_nxt = ST_WAIT_ROW;
      ST_WAIT_ROW:
        if (abort)        state_nxt = ST_DONE;
        else if (hr_rise) state_nxt = row_keep ? ST_ROW_CAPTURE : ST_ROW_SKIP;
      ST_ROW_CAPTURE:
        if (abort || last_px) state_nxt = ST_DONE;
        else if (hr_fall)     state_nxt = ST_WAIT_ROW;
      ST_ROW_SKIP:
        if (abort)        state_nxt = ST_DONE;
        else if (hr_fall) state_nxt = ST_WAIT_ROW;
      ST_DONE:        state_nxt = capture_en ? ST_WAIT_FRAME : ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // control strobes
  always_comb begin
    in_frame = (state == ST_WAIT_ROW) || (state == ST_ROW_CAPTURE) ||
               (state == ST_ROW_SKIP);
    abort    = in_frame && vs_rise;
    row_keep = (src_row_m == 3'd0) && (out_row < H_L);
    // the first byte of a kept row arrives on the same edge as href rising
    cap_byte = href && !abort &&
               ((state == ST_ROW_CAPTURE) ||
                ((state == ST_WAIT_ROW) && hr_rise && row_keep));
    pix_done = cap_byte && phase;
    col_keep = (src_col_m == 3'd0) && (out_col < W_L);
    wr_en    = pix_done && col_keep;
    last_px  = wr_en && (out_row == H_LAST) && (out_col == W_LAST);
    row_end  = hr_fall && !abort &&
               ((state == ST_ROW_CAPTURE) || (state == ST_ROW_SKIP));
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q         <= 1'b0;
      href_q          <= 1'b0;
      phase           <= 1'b0;
      hi_byte         <= '0;
      src_col_m       <= '0;
      src_row_m       <= '0;
      out_col         <= '0;
      out_row         <= '0;
      row_base        <= '0;
      DP_RAM_regW     <= 1'b0;
      DP_RAM_addr_out <= '0;
      DP_RAM_data_out <= '0;
      frame_done      <= 1'b0;
      frame_short     <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      href_q      <= href;
      DP_RAM_regW <= wr_en;
      if (wr_en) begin
        DP_RAM_addr_out <= row_base + out_col;
        DP_RAM_data_out <= pix_conv;
      end
      frame_done <= (state == ST_DONE);
      if (last_px)    frame_short <= 1'b0;
      else if (abort) frame_short <= 1'b1;

      if ((state == ST_WAIT_FRAME) && vs_fall) begin
        phase     <= 1'b0;
        src_col_m <= '0;
        src_row_m <= '0;
        out_col   <= '0;
        out_row   <= '0;
        row_base  <= '0;
      end else begin
        if (cap_byte) begin
          phase <= ~phase;
          if (!phase) hi_byte <= data;
        end
        if (pix_done) begin
          src_col_m <= (src_col_m == DX_MAX) ? 3'd0 : src_col_m + 3'd1;
          if (wr_en) out_col <= out_col + AW'(1);
        end
        // row end drops any half pixel; a captured row always advances
        // to the next row base even if it was short
        if (row_end) begin
          phase     <= 1'b0;
          src_col_m <= '0;
          src_row_m <= (src_row_m == DY_MAX) ? 3'd0 : src_row_m + 3'd1;
          if (state == ST_ROW_CAPTURE) begin
            out_row  <= out_row + AW'(1);
            row_base <= row_base + W_L;
            out_col  <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_scaler.sv
module tb_cam_capture_scaler;

  logic       pclk = 1'b0, rst_n = 1'b0, href = 1'b0, vsync = 1'b1, capture_en = 1'b0;
  logic [7:0] data = 8'h00;

  always #5 pclk = ~pclk;

  // A: 4x3 out, decimate 2x2, RGB332
  logic [5:0]  addr_a;  logic [7:0]  data_a;  logic regw_a, fd_a_s, short_a;
  // B: 4x2 out, no decimation, RGB565
  logic [5:0]  addr_b;  logic [15:0] data_b;  logic regw_b, fd_b_s, short_b;
  // C: same as B, RGB444
  logic [5:0]  addr_c;  logic [11:0] data_c;  logic regw_c, fd_c_s, short_c;

  cam_capture_scaler #(.IMG_W(4), .IMG_H(3), .DEC_X(2), .DEC_Y(2), .OUT_FMT(0), .AW(6)) u_a (
    .pclk(pclk), .rst_n(rst_n), .data(data), .href(href), .vsync(vsync), .capture_en(capture_en),
    .DP_RAM_addr_out(addr_a), .DP_RAM_data_out(data_a), .DP_RAM_regW(regw_a),
    .frame_done(fd_a_s), .frame_short(short_a));
  cam_capture_scaler #(.IMG_W(4), .IMG_H(2), .DEC_X(1), .DEC_Y(1), .OUT_FMT(2), .AW(6)) u_b (
    .pclk(pclk), .rst_n(rst_n), .data(data), .href(href), .vsync(vsync), .capture_en(capture_en),
    .DP_RAM_addr_out(addr_b), .DP_RAM_data_out(data_b), .DP_RAM_regW(regw_b),
    .frame_done(fd_b_s), .frame_short(short_b));
  cam_capture_scaler #(.IMG_W(4), .IMG_H(2), .DEC_X(1), .DEC_Y(1), .OUT_FMT(1), .AW(6)) u_c (
    .pclk(pclk), .rst_n(rst_n), .data(data), .href(href), .vsync(vsync), .capture_en(capture_en),
    .DP_RAM_addr_out(addr_c), .DP_RAM_data_out(data_c), .DP_RAM_regW(regw_c),
    .frame_done(fd_c_s), .frame_short(short_c));

  int n_cmp = 0, n_bad = 0, frame_id = 0;
  int cnt_a = 0, cnt_b = 0, fd_a = 0, fd_b = 0, last_a = 0, last_b = 0;
  int mem_a[64], wf_a[64], mem_b[64], wf_b[64], mem_c[64];
  int ca, cb, fa, fb;

  // write monitor: RAM image per DUT, tagged with the frame that wrote it
  always @(negedge pclk) begin
    if (regw_a === 1'b1) begin
      cnt_a++; mem_a[addr_a] = int'(data_a); wf_a[addr_a] = frame_id; last_a = int'(addr_a);
    end
    if (regw_b === 1'b1) begin
      cnt_b++; mem_b[addr_b] = int'(data_b); wf_b[addr_b] = frame_id; last_b = int'(addr_b);
    end
    if (regw_c === 1'b1) mem_c[addr_c] = int'(data_c);
    if (fd_a_s === 1'b1) fd_a++;
    if (fd_b_s === 1'b1) fd_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int mode, input int r, input int c);
    case (mode)
      0:       return 16'(c);
      1:       return 16'hF800;
      default: return {8'(r + 1), 8'(c + 16)};
    endcase
  endfunction

  task automatic mark();
    frame_id++; ca = cnt_a; cb = cnt_b; fa = fd_a; fb = fd_b;
  endtask

  task automatic send_bytes(input int r, input int k0, input int k1, input int mode);
    logic [15:0] p;
    for (int k = k0; k <= k1; k++) begin
      p     = pix(mode, r, k / 2);
      data  = (k % 2 == 0) ? p[15:8] : p[7:0];
      href  = 1'b1;
      @(negedge pclk);
    end
  endtask

  task automatic row_gap();
    href = 1'b0; data = 8'h00;
    repeat (3) @(negedge pclk);
  endtask

  task automatic send_row(input int r, input int nbytes, input int mode);
    send_bytes(r, 0, nbytes - 1, mode);
    row_gap();
  endtask

  task automatic frame_begin();
    vsync = 1'b1; repeat (3) @(negedge pclk);
    vsync = 1'b0; repeat (2) @(negedge pclk);
  endtask

  task automatic frame_end();
    vsync = 1'b1; repeat (6) @(negedge pclk);
  endtask

  task automatic full_frame(input int mode);
    frame_begin();
    for (int r = 0; r < 6; r++) send_row(r, 16, mode);
    frame_end();
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge pclk);
    chk("rst_addr_a", addr_a, 0);   chk("rst_data_a", data_a, 0);
    chk("rst_regw_a", regw_a, 0);   chk("rst_fd_a", fd_a_s, 0);
    chk("rst_short_a", short_a, 0); chk("rst_data_b", data_b, 0);
    rst_n = 1'b1; capture_en = 1'b1;
    repeat (2) @(negedge pclk);

    // frame 1: pixel = column index
    mark(); full_frame(0);
    chk("f1_cnt_a", cnt_a - ca, 12);  chk("f1_last_a", last_a, 11);
    chk("f1_fd_a", fd_a - fa, 1);     chk("f1_short_a", short_a, 0);
    chk("f1_cnt_b", cnt_b - cb, 8);   chk("f1_fd_b", fd_b - fb, 1);
    chk("f1_b0", mem_b[0], 0); chk("f1_b1", mem_b[1], 1);
    chk("f1_b3", mem_b[3], 3); chk("f1_b4_wr", wf_b[4], frame_id);
    chk("f1_b4", mem_b[4], 0); chk("f1_b6", mem_b[6], 2);
    chk("f1_c1", mem_c[1], 0); chk("f1_c3", mem_c[3], 1);

    // frame 2: solid 0xF800
    mark(); full_frame(1);
    chk("f2_cnt_a", cnt_a - ca, 12); chk("f2_a0", mem_a[0], 'hE0);
    chk("f2_a11", mem_a[11], 'hE0);  chk("f2_b7", mem_b[7], 'hF800);
    chk("f2_c2", mem_c[2], 'hF00);   chk("f2_short_b", short_b, 0);

    // frame 3: vsync rises after 3 source rows (A has kept only 2 of 3)
    mark(); frame_begin();
    for (int r = 0; r < 3; r++) send_row(r, 16, 1);
    frame_end();
    chk("f3_cnt_a", cnt_a - ca, 8);  chk("f3_last_a", last_a, 7);
    chk("f3_fd_a", fd_a - fa, 1);    chk("f3_short_a", short_a, 1);
    chk("f3_cnt_b", cnt_b - cb, 8);  chk("f3_short_b", short_b, 0);

    // frame 4: first row has 7 bytes (half pixel dropped)
    mark(); frame_begin();
    send_row(0, 7, 2);
    for (int r = 1; r < 5; r++) send_row(r, 16, 2);
    frame_end();
    chk("f4_cnt_b", cnt_b - cb, 7);      chk("f4_b2", mem_b[2], 'h0112);
    chk("f4_b3_skip", wf_b[3] == frame_id, 0);
    chk("f4_b4", mem_b[4], 'h0210);      chk("f4_short_b", short_b, 0);
    chk("f4_cnt_a", cnt_a - ca, 10);     chk("f4_last_a", last_a, 11);
    chk("f4_a2_skip", wf_a[2] == frame_id, 0);
    chk("f4_a4_wr", wf_a[4], frame_id);  chk("f4_short_a", short_a, 0);
    chk("f4_fd_a", fd_a - fa, 1);

    // frame 5: reset mid-row while a write is on the bus
    frame_begin();
    send_bytes(0, 0, 1, 2);
    chk("f5_lat_regw_b", regw_b, 1); chk("f5_lat_data_b", data_b, 'h0110);
    rst_n = 1'b0; #1;
    chk("f5_rst_regw_b", regw_b, 0); chk("f5_rst_data_b", data_b, 0);
    chk("f5_rst_regw_a", regw_a, 0); chk("f5_rst_fd_b", fd_b_s, 0);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    mark();
    send_bytes(0, 2, 15, 2); row_gap();
    for (int r = 1; r < 6; r++) send_row(r, 16, 2);
    frame_end();
    chk("f5_cnt_a", cnt_a - ca, 0); chk("f5_cnt_b", cnt_b - cb, 0);
    chk("f5_fd_b", fd_b - fb, 0);

    // frame 5b: restart at address 0; capture_en dropped mid-frame
    mark(); frame_begin();
    send_row(0, 16, 1);
    capture_en = 1'b0;
    for (int r = 1; r < 6; r++) send_row(r, 16, 1);
    frame_end();
    chk("f5b_a0_wr", wf_a[0], frame_id); chk("f5b_cnt_a", cnt_a - ca, 12);
    chk("f5b_last_a", last_a, 11);       chk("f5b_cnt_b", cnt_b - cb, 8);
    chk("f5b_fd_b", fd_b - fb, 1);

    // frame 6: not armed at frame start, armed mid-frame
    mark(); frame_begin();
    send_row(0, 16, 2);
    capture_en = 1'b1;
    for (int r = 1; r < 6; r++) send_row(r, 16, 2);
    frame_end();
    chk("f6_cnt_a", cnt_a - ca, 0); chk("f6_cnt_b", cnt_b - cb, 0);
    chk("f6_fd_a", fd_a - fa, 0);

    // frame 7: captured normally
    mark(); full_frame(2);
    chk("f7_cnt_a", cnt_a - ca, 12); chk("f7_a5", mem_a[5], 'h0E);
    chk("f7_b5", mem_b[5], 'h0211);  chk("f7_c5", mem_c[5], 'h048);
    chk("f7_fd_b", fd_b - fb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
